// File: rtl/ro_meas_pkg.sv
// Shared state encoding, parameter defaults and Gray decode for the
// ring-oscillator measurement scheduler.
package ro_meas_pkg;

  localparam int N_OSC_DEF       = 4;
  localparam int BUS_WIDTH_DEF   = 32;
  localparam int CLR_CYCLES_DEF  = 2;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int GRAY_MAX_W      = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Callers zero-extend narrower codes; leading zeros decode to leading zeros.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] i_gray);
    logic [GRAY_MAX_W-1:0] v_bin;
    v_bin[GRAY_MAX_W-1] = i_gray[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      v_bin[i] = v_bin[i+1] ^ i_gray[i];
    end
    return v_bin;
  endfunction

endpackage

// File: rtl/ro_gray_sync.sv
// Multi-flop synchronizer for the Gray-coded oscillator count; the count is
// frozen before it is sampled, so per-bit synchronization is safe.
module ro_gray_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_gray
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_gray;
      for (int i = 1; i < STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_gray = r_stage[STAGES-1];

endmodule

// File: rtl/ro_meas_sched.sv
// Ring-oscillator measurement scheduler: clear, gate, settle and capture one
// oscillator count per request. Define RO_SCHED_SWEEP_EN to add index sweeps.
//
// state   | meaning
// IDLE    | waiting for a request or sweep trigger, req_ready high
// CLEAR   | osc_clr[sel] held for CLR_CYCLES cycles
// RUN     | osc_en[sel] held for the requested window
// SETTLE  | oscillator gated off, synchronizer flushing
// CAPTURE | decode synchronized Gray count into the result registers
// DONE    | result held on res_* until res_ack
module ro_meas_sched
  import ro_meas_pkg::*;
#(
  parameter int N_OSC       = N_OSC_DEF,
  parameter int BUS_WIDTH   = BUS_WIDTH_DEF,
  parameter int CLR_CYCLES  = CLR_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_sel,
  input  logic [BUS_WIDTH-1:0] req_window,
  input  logic                 sweep_start,
  output logic [N_OSC-1:0]     osc_en,
  output logic [N_OSC-1:0]     osc_clr,
  input  logic [BUS_WIDTH-1:0] osc_cnt_gray,
  output logic                 res_valid,
  input  logic                 res_ack,
  output logic [BUS_WIDTH-2:0] res_count,
  output logic [3:0]           res_sel,
  output logic                 res_ovf,
  output logic                 res_err
);

  localparam logic [4:0] LP_N_OSC = 5'(N_OSC);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [3:0]             r_sel;
  logic [BUS_WIDTH-1:0]   r_window;
  logic [BUS_WIDTH-1:0]   r_cnt;
  logic [BUS_WIDTH-2:0]   r_res_count;
  logic [3:0]             r_res_sel;
  logic                   r_res_ovf;
  logic                   r_res_err;

  logic                   w_cnt_tc;
  logic                   w_sweep_go;
  logic                   w_sweep_more;
  logic                   w_launch;
  logic [3:0]             w_launch_sel;
  logic [BUS_WIDTH-1:0]   w_launch_win;
  logic                   w_launch_bad;
  logic                   w_launch_short;
  logic [N_OSC-1:0]       w_sel_onehot;
  logic [BUS_WIDTH-1:0]   w_sync_gray;
  logic [GRAY_MAX_W-1:0]  w_bin_ext;
  logic                   w_sat;

  ro_gray_sync #(
    .WIDTH  (BUS_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_gray_sync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_gray  (osc_cnt_gray),
    .o_gray  (w_sync_gray)
  );

`ifdef RO_SCHED_SWEEP_EN
  localparam logic [3:0] LP_LAST_SEL = 4'(N_OSC - 1);
  logic r_sweep;

  assign w_sweep_go   = sweep_start && (r_state == S_IDLE);
  assign w_sweep_more = r_sweep && (r_sel != LP_LAST_SEL);

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_sweep <= 1'b0;
    end else if (w_sweep_go) begin
      r_sweep <= 1'b1;
    end else if ((r_state == S_DONE) && res_ack && !w_sweep_more) begin
      r_sweep <= 1'b0;
    end
  end
`else
  logic w_sweep_unused;
  assign w_sweep_unused = sweep_start;
  assign w_sweep_go     = 1'b0;
  assign w_sweep_more   = 1'b0;
`endif

  // A launch starts a measurement from IDLE or chains the next sweep index out of DONE.
  assign w_launch = ((r_state == S_IDLE) && (w_sweep_go || req_valid)) ||
                    ((r_state == S_DONE) && res_ack && w_sweep_more);
  assign w_launch_sel = (r_state == S_DONE) ? (r_sel + 4'd1) :
                        (w_sweep_go ? 4'd0 : req_sel);
  assign w_launch_win   = ((r_state == S_DONE) || w_sweep_go) ? r_window : req_window;
  assign w_launch_bad   = ({1'b0, w_launch_sel} >= LP_N_OSC);
  assign w_launch_short = w_launch_bad || (w_launch_win == '0);

  assign w_cnt_tc     = (r_cnt == '0);
  assign w_sel_onehot = N_OSC'(1) << r_sel;
  assign w_bin_ext    = gray2bin(GRAY_MAX_W'(w_sync_gray));
  assign w_sat        = |w_bin_ext[GRAY_MAX_W-1:BUS_WIDTH-1];

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    res_valid   = 1'b0;
    osc_en      = '0;
    osc_clr     = '0;
    unique case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_launch) w_state_nxt = w_launch_short ? S_DONE : S_CLEAR;
      end
      S_CLEAR: begin
        osc_clr = w_sel_onehot;
        if (w_cnt_tc) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        osc_en = w_sel_onehot;
        if (w_cnt_tc) w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_cnt_tc) w_state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ack) begin
          if (w_launch) w_state_nxt = w_launch_short ? S_DONE : S_CLEAR;
          else          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_sel       <= '0;
      r_window    <= '0;
      r_cnt       <= '0;
      r_res_count <= '0;
      r_res_sel   <= '0;
      r_res_ovf   <= 1'b0;
      r_res_err   <= 1'b0;
    end else if (w_launch) begin
      r_sel    <= w_launch_sel;
      r_window <= w_launch_win;
      r_cnt    <= BUS_WIDTH'(CLR_CYCLES - 1);
      if (w_launch_short) begin
        r_res_count <= '0;
        r_res_sel   <= w_launch_sel;
        r_res_ovf   <= 1'b0;
        r_res_err   <= w_launch_bad;
      end
    end else begin
      case (r_state)
        S_CLEAR: r_cnt <= w_cnt_tc ? (r_window - BUS_WIDTH'(1)) : (r_cnt - BUS_WIDTH'(1));
        S_RUN:   r_cnt <= w_cnt_tc ? BUS_WIDTH'(SYNC_STAGES + 1) : (r_cnt - BUS_WIDTH'(1));
        S_SETTLE: r_cnt <= r_cnt - BUS_WIDTH'(1);
        S_CAPTURE: begin
          r_res_sel   <= r_sel;
          r_res_err   <= 1'b0;
          r_res_ovf   <= w_sat;
          r_res_count <= w_sat ? '1 : w_bin_ext[BUS_WIDTH-2:0];
        end
        default: ;
      endcase
    end
  end

  assign res_count = r_res_count;
  assign res_sel   = r_res_sel;
  assign res_ovf   = r_res_ovf;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_ro_meas_sched.sv
// Self-checking bench for ro_meas_sched: table vectors, randomized requests
// against a rule-level model, reset-in-RUN and sweep sequences.
`timescale 1ns/1ps
module tb_ro_meas_sched;

  localparam int N  = 4;
  localparam int BW = 32;
  localparam int CLR = 2;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b0;
  logic          req_valid = 1'b0;
  logic [3:0]    req_sel = '0;
  logic [BW-1:0] req_window = '0;
  logic          sweep_start = 1'b0;
  logic [BW-1:0] osc_cnt_gray = '0;
  logic          res_ack = 1'b0;
  logic          req_ready;
  logic [N-1:0]  osc_en;
  logic [N-1:0]  osc_clr;
  logic          res_valid;
  logic [BW-2:0] res_count;
  logic [3:0]    res_sel;
  logic          res_ovf;
  logic          res_err;

  ro_meas_sched #(
    .N_OSC(N), .BUS_WIDTH(BW), .CLR_CYCLES(CLR), .SYNC_STAGES(2)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_window(req_window), .sweep_start(sweep_start),
    .osc_en(osc_en), .osc_clr(osc_clr), .osc_cnt_gray(osc_cnt_gray),
    .res_valid(res_valid), .res_ack(res_ack), .res_count(res_count),
    .res_sel(res_sel), .res_ovf(res_ovf), .res_err(res_err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]    sel;
    logic [BW-1:0] win;
    logic [BW-1:0] cnt;
    logic [BW-2:0] exp_count;
    logic          exp_ovf;
    logic          exp_err;
  } vec_t;

  int total = 0;
  int bad = 0;
  int en_tot [16];
  int clr_tot [16];
  int multi_tot = 0;

  // Cumulative pulse counters; tests take before/after differences.
  always @(negedge Clk) begin
    for (int b = 0; b < N; b++) begin
      if (osc_en[b])  en_tot[b]++;
      if (osc_clr[b]) clr_tot[b]++;
    end
    if ($countones(osc_en) > 1) multi_tot++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
    #1;
  endtask

  function automatic vec_t model(input logic [3:0] s, input logic [BW-1:0] w, input logic [BW-1:0] c);
    vec_t v;
    v.sel = s; v.win = w; v.cnt = c;
    v.exp_err = (int'(s) >= N);
    if (v.exp_err || w == 0) begin
      v.exp_count = '0; v.exp_ovf = 1'b0;
    end else if (c >= 32'h8000_0000) begin
      v.exp_count = '1; v.exp_ovf = 1'b1;
    end else begin
      v.exp_count = c[BW-2:0]; v.exp_ovf = 1'b0;
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int en0 [16];
    int clr0 [16];
    int m0, guard, exp_en, exp_clr, en_sel, clr_sel, sum_en, sum_clr;
    guard = 0;
    while (!req_ready && guard < 200) begin tick(); guard++; end
    chk("ready_before_req", req_ready, 1);
    osc_cnt_gray = v.cnt ^ (v.cnt >> 1);
    en0 = en_tot; clr0 = clr_tot; m0 = multi_tot;
    req_valid = 1'b1; req_sel = v.sel; req_window = v.win;
    tick();
    // Requests arriving while busy must be ignored.
    req_sel = 4'($urandom_range(0, 15));
    req_window = BW'($urandom_range(1, 50));
    guard = 0;
    while (!res_valid && guard < int'(v.win) + 60) begin tick(); guard++; end
    req_valid = 1'b0;
    chk("res_valid_seen", res_valid, 1);
    chk("res_count", res_count, v.exp_count);
    chk("res_sel", res_sel, v.sel);
    chk("res_ovf", res_ovf, v.exp_ovf);
    chk("res_err", res_err, v.exp_err);
    chk("ready_busy", req_ready, 0);
    repeat ($urandom_range(1, 3)) tick();
    chk("hold_valid", res_valid, 1);
    chk("hold_count", res_count, v.exp_count);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("valid_after_ack", res_valid, 0);
    chk("ready_after_ack", req_ready, 1);
    exp_en  = (v.exp_err || v.win == 0) ? 0 : int'(v.win);
    exp_clr = (v.exp_err || v.win == 0) ? 0 : CLR;
    en_sel = 0; clr_sel = 0; sum_en = 0; sum_clr = 0;
    for (int b = 0; b < N; b++) begin
      sum_en  += en_tot[b] - en0[b];
      sum_clr += clr_tot[b] - clr0[b];
      if (b == int'(v.sel)) begin
        en_sel  = en_tot[b] - en0[b];
        clr_sel = clr_tot[b] - clr0[b];
      end
    end
    chk("en_cycles_sel", en_sel, exp_en);
    chk("en_cycles_all", sum_en, exp_en);
    chk("clr_cycles_sel", clr_sel, exp_clr);
    chk("clr_cycles_all", sum_clr, exp_clr);
    chk("en_onehot", multi_tot - m0, 0);
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    int guard, e0;
    tbl[0] = '{4'd1, 32'd100, 32'd1234,       31'd1234,         1'b0, 1'b0};
    tbl[1] = '{4'd0, 32'd5,   32'h8000_0005,  31'h7FFF_FFFF,    1'b1, 1'b0};
    tbl[2] = '{4'd2, 32'd0,   32'd55,         31'd0,            1'b0, 1'b0};
    tbl[3] = '{4'd7, 32'd20,  32'd99,         31'd0,            1'b0, 1'b1};
    tbl[4] = '{4'd3, 32'd1,   32'h7FFF_FFFF,  31'h7FFF_FFFF,    1'b0, 1'b0};
    tbl[5] = '{4'd2, 32'd3,   32'h8000_0000,  31'h7FFF_FFFF,    1'b1, 1'b0};
    tbl[6] = '{4'd0, 32'd2,   32'd0,          31'd0,            1'b0, 1'b0};
    tbl[7] = '{4'd4, 32'd10,  32'd5,          31'd0,            1'b0, 1'b1};

    Reset_n = 1'b0;
    repeat (3) tick();
    Reset_n = 1'b1;
    tick();
    chk("rst_osc_en", osc_en, 0);
    chk("rst_osc_clr", osc_clr, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_count", res_count, 0);
    chk("rst_res_sel", res_sel, 0);
    chk("rst_res_flags", {res_ovf, res_err}, 0);
    chk("rst_ready", req_ready, 1);

    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    for (int i = 0; i < 24; i++) begin
      rv = model(4'($urandom_range(0, 5)),
                 ($urandom_range(0, 5) == 0) ? '0 : BW'($urandom_range(1, 40)),
                 $urandom);
      run_vec(rv);
    end

    // Reset asserted in the 50th RUN cycle of a 100-cycle window.
    osc_cnt_gray = 32'd777 ^ (32'd777 >> 1);
    req_valid = 1'b1; req_sel = 4'd1; req_window = 32'd100;
    tick();
    req_valid = 1'b0;
    e0 = en_tot[1];
    guard = 0;
    while ((en_tot[1] - e0) < 50 && guard < 200) begin tick(); guard++; end
    chk("rst_run_reached", en_tot[1] - e0, 50);
    Reset_n = 1'b0;
    tick();
    chk("rst_run_en_off", osc_en, 0);
    chk("rst_run_idle", req_ready, 1);
    chk("rst_run_valid", res_valid, 0);
    chk("rst_run_count", res_count, 0);
    Reset_n = 1'b1;
    repeat (3) tick();
    chk("rst_run_no_more_en", en_tot[1] - e0, 50);
    chk("rst_run_still_idle", res_valid, 0);

`ifdef RO_SCHED_SWEEP_EN
    begin
      int en0 [16];
      run_vec(model(4'd0, 32'd10, 32'd321));
      en0 = en_tot;
      osc_cnt_gray = 32'd4321 ^ (32'd4321 >> 1);
      sweep_start = 1'b1; req_valid = 1'b1; req_sel = 4'd2; req_window = 32'd77;
      tick();
      sweep_start = 1'b0; req_valid = 1'b0;
      for (int k = 0; k < N; k++) begin
        guard = 0;
        while (!res_valid && guard < 100) begin tick(); guard++; end
        chk("sweep_valid", res_valid, 1);
        chk("sweep_sel", res_sel, k);
        chk("sweep_count", res_count, 4321);
        chk("sweep_ready_low", req_ready, 0);
        repeat (3) tick();
        chk("sweep_hold_sel", res_sel, k);
        chk("sweep_hold_valid", res_valid, 1);
        res_ack = 1'b1;
        tick();
        res_ack = 1'b0;
      end
      chk("sweep_ready_end", req_ready, 1);
      for (int b = 0; b < N; b++) chk("sweep_en_cycles", en_tot[b] - en0[b], 10);
    end
`else
    begin
      int en0 [16];
      en0 = en_tot;
      sweep_start = 1'b1;
      tick();
      sweep_start = 1'b0;
      repeat (5) tick();
      chk("sweep_ignored_ready", req_ready, 1);
      chk("sweep_ignored_valid", res_valid, 0);
      chk("sweep_ignored_en", en_tot[0] - en0[0], 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ro_meas_sched.md
RO_MEAS_SCHED -- requirements
Module: ro_meas_sched

Interface
REQ-001 SHALL have parameter N_OSC, default 4, number of ring-oscillator instances sequenced (2..16).
REQ-002 SHALL have parameter BUS_WIDTH, default 32, width of window and count values.
REQ-003 SHALL have parameter CLR_CYCLES, default 2, cycles osc_clr is held before a run.
REQ-004 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on osc_cnt_gray.
REQ-005 SHALL have port Clk, input, 1, the single clock; all logic samples its rising edge.
REQ-006 SHALL have port Reset_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port req_valid, input, 1, measurement request.
REQ-008 SHALL have port req_ready, output, 1, high only in IDLE.
REQ-009 SHALL have port req_sel, input, 4, oscillator index.
REQ-010 SHALL have port req_window, input, BUS_WIDTH, gate length in Clk cycles.
REQ-011 SHALL have port sweep_start, input, 1, one-cycle sweep trigger.
REQ-012 SHALL have port osc_en, output, N_OSC, one-hot oscillator enable.
REQ-013 SHALL have port osc_clr, output, N_OSC, one-hot counter clear.
REQ-014 SHALL have port osc_cnt_gray, input, BUS_WIDTH, Gray-coded count of the enabled oscillator, asynchronous to Clk.
REQ-015 SHALL have port res_valid, output, 1, result available.
REQ-016 SHALL have port res_ack, input, 1, result consumed.
REQ-017 SHALL have port res_count, output, BUS_WIDTH-1, measured edge count.
REQ-018 SHALL have port res_sel, output, 4, index measured.
REQ-019 SHALL have ports res_ovf and res_err, output, 1 each: saturation flag and bad-index flag.

Function
REQ-020 SHALL implement states IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE.
REQ-021 SHALL accept a request only when req_valid and req_ready are both high, latching req_sel and req_window, and go to CLEAR on the next edge.
REQ-022 SHALL assert osc_clr[sel] for exactly CLR_CYCLES cycles in CLEAR, then go to RUN.
REQ-023 SHALL assert osc_en[sel] for exactly req_window cycles in RUN, with at most one osc_en bit high at any time.
REQ-024 SHALL hold all osc_en bits low for SYNC_STAGES+2 cycles in SETTLE.
REQ-025 SHALL, in CAPTURE, Gray-to-binary convert the synchronized count in one cycle, register it into res_count/res_sel, then go to DONE.
REQ-026 SHALL, when the binary count is at least 2^(BUS_WIDTH-1), set res_count to all ones and res_ovf=1; otherwise res_ovf=0.
REQ-027 SHALL, for req_window==0, skip CLEAR/RUN/SETTLE and go directly to DONE with res_count=0 and no osc_en pulse.
REQ-028 SHALL, for req_sel>=N_OSC, drive no osc_en/osc_clr and go directly to DONE with res_err=1 and res_count=0.
REQ-029 SHALL hold res_valid and all result fields stable in DONE until res_ack, then return to IDLE on the next edge; res_ack in any other state SHALL be ignored.
REQ-030 SHALL ignore req_valid and sweep_start outside IDLE; when both arrive together in IDLE, sweep_start SHALL win.

Reset
REQ-031 SHALL, with Reset_n low at a Clk edge, enter IDLE and clear osc_en, osc_clr, res_valid, res_count, res_sel, res_ovf, res_err, sweep index and synchronizer flops to 0.
REQ-032 SHALL, on reset during RUN, drop osc_en on that same edge and discard the partial measurement.

Configuration
REQ-033 SHALL, with RO_SCHED_SWEEP_EN defined, treat sweep_start in IDLE as a run of indices 0..N_OSC-1 using the last latched req_window, presenting each result through the DONE/res_ack handshake and keeping req_ready low until the last ack.
REQ-034 SHALL, without RO_SCHED_SWEEP_EN, keep the sweep_start port but ignore it, with no sweep logic compiled in.

Structure
REQ-035 SHALL place the state enum, the default parameters and the Gray-to-binary function in package ro_meas_pkg.
REQ-036 SHALL instantiate sub-module ro_gray_sync (SYNC_STAGES-deep flop chain on osc_cnt_gray) once.

Verification
REQ-037 SHALL cover: sel=1, window=100 -> osc_en[1] high for exactly 100 cycles, osc_clr[1] for 2 cycles, res_sel=1, res_count equals the model count.
REQ-038 SHALL cover: window=0 -> res_valid with count 0, no osc_en pulse.
REQ-039 SHALL cover: sel=7 with N_OSC=4 -> res_err=1, osc_en stays 0.
REQ-040 SHALL cover: model count 0x80000005 -> res_count=0x7FFFFFFF, res_ovf=1.
REQ-041 SHALL cover: Reset_n low at RUN cycle 50 -> osc_en is 0 on that edge, state is IDLE, res_valid is 0.
REQ-042 SHALL cover, with RO_SCHED_SWEEP_EN: sweep_start, window=10 -> four results, res_sel 0,1,2,3 in order, each held until res_ack.
